serial_adder: RTL

Parametrised, multi-cycle successor to the single-bit full adder. Adds two WIDTH-bit operands plus carry-in over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle through a registered carry chain. Valid/ready handshakes on input and output let it sit between register stages in datapaths where a full-width single-cycle adder is too large or too slow. Produces sum, carry-out and signed overflow.

---
 rtl/serial_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder. Adds a + b + cin over WIDTH/DIGIT cycles,
// DIGIT bits at a time through a registered carry, with valid/ready on both
// sides. Reports sum, unsigned carry-out and two's-complement overflow.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       a_sh, b_sh, sum_sh;
  logic                   carry, a_msb, b_msb;
  logic [CW-1:0]          cnt;
  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_nxt;
  logic                   accept, last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == RUN) && (cnt == LAST);

  // One digit of the addition; the new digit enters the sum register from the top
  always_comb begin
    dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    sum_cat = {dsum[DIGIT-1:0], sum_sh};
    sum_nxt = sum_cat[WIDTH+DIGIT-1:DIGIT];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Input handshake is decoded from the state register only
  always_comb begin
    in_ready = (state == IDLE);
  end

  // Operand/sum shift registers, carry chain and registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      cnt       <= '0;
      s         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      sum_sh <= '0;
      carry  <= cin;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      sum_sh <= sum_nxt;
      carry  <= dsum[DIGIT];
      cnt    <= cnt + CW'(1);
      if (last) begin
        // Overflow only possible when both operands share a sign
        s         <= sum_nxt;
        co        <= dsum[DIGIT];
        ovf       <= (a_msb == b_msb) && (sum_nxt[WIDTH-1] != a_msb);
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
